// File: rtl/vga_update_scheduler_if.sv
// Display-update handshake bundle between the RTC/configuration logic
// (master) and the frame-synchronous update scheduler (slave).
interface vga_update_scheduler_if #(
    parameter int DATA_W = 79
);
    logic              upd_req;
    logic [DATA_W-1:0] upd_data;
    logic              upd_ack;

    modport master (
        output upd_req,
        output upd_data,
        input  upd_ack
    );

    modport slave (
        input  upd_req,
        input  upd_data,
        output upd_ack
    );
endinterface

// File: rtl/vga_update_scheduler.sv
// Frame-synchronous update scheduler for the VGA display path.
// Accepts display-bundle updates over a 4-phase req/ack handshake and commits
// them to a shadow register only during vertical blanking, so the character
// generator never sees a mid-frame change. Also derives frame-locked alarm and
// cursor blink enables from a single vblank-entry pulse.
module vga_update_scheduler #(
    parameter int DATA_W        = 79,
    parameter int V_VISIBLE     = 480,
    parameter int BLINK_FRAMES  = 20,
    parameter int CURSOR_FRAMES = 30
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   pixel_tick,
    input  logic [9:0]             pixel_x,
    input  logic [9:0]             pixel_y,
    vga_update_scheduler_if.slave  upd,
    output logic [DATA_W-1:0]      disp_data,
    output logic                   upd_pending,
    output logic                   frame_tick,
    output logic                   blink,
    output logic                   blink_cursor
);

    // Counter widths; guard against degenerate 1-frame periods.
    localparam int BLINK_W  = (BLINK_FRAMES  > 1) ? $clog2(BLINK_FRAMES)  : 1;
    localparam int CURSOR_W = (CURSOR_FRAMES > 1) ? $clog2(CURSOR_FRAMES) : 1;

    localparam logic [9:0]          V_VISIBLE_Y  = 10'(V_VISIBLE);
    localparam logic [BLINK_W-1:0]  BLINK_LAST   = BLINK_W'(BLINK_FRAMES - 1);
    localparam logic [CURSOR_W-1:0] CURSOR_LAST  = CURSOR_W'(CURSOR_FRAMES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_VB = 2'd1,
        LATCH   = 2'd2,
        REL     = 2'd3
    } state_t;

    state_t              state_q;
    logic                ack_q;
    logic                pending_q;
    logic [DATA_W-1:0]   disp_q;

    logic                frame_tick_q;
    logic                frame_tick_d;

    logic [BLINK_W-1:0]  blink_cnt_q;
    logic [BLINK_W-1:0]  blink_cnt_d;
    logic                blink_q;
    logic                blink_d;

    logic [CURSOR_W-1:0] cursor_cnt_q;
    logic [CURSOR_W-1:0] cursor_cnt_d;
    logic                cursor_q;
    logic                cursor_d;

    logic                in_vblank;

    // Rows at or below the visible height are blanking; safe to commit there.
    assign in_vblank = (pixel_y >= V_VISIBLE_Y);

    // Vblank entry is the single pixel at column 0 of the first blanking row,
    // so the 524->0 wrap and the other blanking rows never fire it.
    always_comb begin
        frame_tick_d = pixel_tick && (pixel_x == 10'd0) && (pixel_y == V_VISIBLE_Y);
    end

    // Register the vblank-entry pulse so it is glitch-free and one clock wide.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            frame_tick_q <= 1'b0;
        end else begin
            frame_tick_q <= frame_tick_d;
        end
    end

    // Blink dividers count frames, not clocks, so both blinks stay locked to
    // the raster and are independent of the update handshake.
    always_comb begin
        blink_cnt_d  = blink_cnt_q;
        blink_d      = blink_q;
        cursor_cnt_d = cursor_cnt_q;
        cursor_d     = cursor_q;
        if (frame_tick_q) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = '0;
                blink_d     = ~blink_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
            if (cursor_cnt_q == CURSOR_LAST) begin
                cursor_cnt_d = '0;
                cursor_d     = ~cursor_q;
            end else begin
                cursor_cnt_d = cursor_cnt_q + 1'b1;
            end
        end
    end

    // Blink counter and toggle state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            blink_cnt_q  <= '0;
            blink_q      <= 1'b0;
            cursor_cnt_q <= '0;
            cursor_q     <= 1'b0;
        end else begin
            blink_cnt_q  <= blink_cnt_d;
            blink_q      <= blink_d;
            cursor_cnt_q <= cursor_cnt_d;
            cursor_q     <= cursor_d;
        end
    end

    // Handshake FSM with registered outputs. The shadow bundle is written only
    // in LATCH, which is reachable only from WAIT_VB after in_vblank was seen,
    // so every commit lands inside blanking. A request is considered only from
    // IDLE, which is entered only as ack falls, so no request is taken while
    // ack is still high.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            ack_q     <= 1'b0;
            pending_q <= 1'b0;
            disp_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (upd.upd_req) begin
                        state_q   <= WAIT_VB;
                        pending_q <= 1'b1;
                    end
                end
                WAIT_VB: begin
                    // A withdrawn request is abandoned silently: no commit, no ack.
                    if (!upd.upd_req) begin
                        state_q   <= IDLE;
                        pending_q <= 1'b0;
                    end else if (in_vblank) begin
                        state_q   <= LATCH;
                        pending_q <= 1'b0;
                    end
                end
                LATCH: begin
                    disp_q  <= upd.upd_data;
                    ack_q   <= 1'b1;
                    state_q <= REL;
                end
                REL: begin
                    if (!upd.upd_req) begin
                        ack_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    ack_q     <= 1'b0;
                    pending_q <= 1'b0;
                end
            endcase
        end
    end

    assign upd.upd_ack   = ack_q;
    assign upd_pending   = pending_q;
    assign disp_data     = disp_q;
    assign frame_tick    = frame_tick_q;
    assign blink         = blink_q;
    assign blink_cursor  = cursor_q;

endmodule

// File: tb/tb_vga_update_scheduler.sv
// Bench for vga_update_scheduler: a compressed raster driver, a transaction-
// level reference model compared every clock, and directed scenarios with
// literal expectations.
module tb_vga_update_scheduler;

    localparam int DATA_W = 79;

    logic              clk = 1'b0;
    logic              rst;
    logic              pixel_tick;
    logic [9:0]        pixel_x;
    logic [9:0]        pixel_y;
    logic [DATA_W-1:0] disp_data;
    logic              upd_pending;
    logic              frame_tick;
    logic              blink;
    logic              blink_cursor;

    int checks   = 0;
    int failures = 0;
    bit fast     = 1'b0;

    vga_update_scheduler_if #(.DATA_W(DATA_W)) bus ();

    vga_update_scheduler #(
        .DATA_W       (DATA_W),
        .V_VISIBLE    (480),
        .BLINK_FRAMES (20),
        .CURSOR_FRAMES(30)
    ) dut (
        .clock       (clk),
        .reset       (rst),
        .pixel_tick  (pixel_tick),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .upd         (bus),
        .disp_data   (disp_data),
        .upd_pending (upd_pending),
        .frame_tick  (frame_tick),
        .blink       (blink),
        .blink_cursor(blink_cursor)
    );

    always #5 clk = ~clk;

    // Compressed raster: 525 rows; two pixels per row (x=0,1) normally, one
    // pixel per row in fast mode. Updated 3 time units after each rising edge.
    initial begin
        pixel_tick = 1'b0;
        pixel_x    = 10'd0;
        pixel_y    = 10'd0;
        forever begin
            @(posedge clk);
            #3;
            pixel_tick = 1'b1;
            if (fast || pixel_x != 10'd0) begin
                pixel_x = 10'd0;
                pixel_y = (pixel_y == 10'd524) ? 10'd0 : pixel_y + 10'd1;
            end else begin
                pixel_x = 10'd1;
            end
        end
    end

    // Reference model: a request is outstanding until blanking is observed,
    // the bundle is taken one clock later and ack is held until req drops.
    // Blink levels follow from the number of frames seen so far.
    logic              m_ack    = 1'b0;
    logic              m_pend   = 1'b0;
    logic              m_commit = 1'b0;
    logic              m_ft     = 1'b0;
    logic [DATA_W-1:0] m_disp   = '0;
    int                m_frames = 0;

    initial begin
        logic n_ft;
        logic [4:0] got;
        logic [4:0] exp;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_ack = 1'b0; m_pend = 1'b0; m_commit = 1'b0;
                m_ft = 1'b0; m_disp = '0; m_frames = 0;
            end else begin
                n_ft = pixel_tick && (pixel_x == 10'd0) && (pixel_y == 10'd480);
                if (m_ft) m_frames++;
                if (m_ack) begin
                    if (!bus.upd_req) m_ack = 1'b0;
                end else if (m_commit) begin
                    m_disp   = bus.upd_data;
                    m_ack    = 1'b1;
                    m_commit = 1'b0;
                end else if (m_pend) begin
                    if (!bus.upd_req) begin
                        m_pend = 1'b0;
                    end else if (pixel_y >= 10'd480) begin
                        m_pend   = 1'b0;
                        m_commit = 1'b1;
                    end
                end else if (bus.upd_req) begin
                    m_pend = 1'b1;
                end
                m_ft = n_ft;
            end
            #1;
            got = {bus.upd_ack, upd_pending, frame_tick, blink, blink_cursor};
            exp = {m_ack, m_pend, m_ft, ((m_frames / 20) % 2) != 0, ((m_frames / 30) % 2) != 0};
            checks++;
            if (got !== exp || disp_data !== m_disp) begin
                failures++;
                $display("FAIL model t=%0t ack/pend/ft/blink/cur actual=%b required=%b disp actual=%0h required=%0h",
                         $time, got, exp, disp_data, m_disp);
            end
        end
    end

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic chkd(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Returns at the falling edge where the raster sits at (y, x=0).
    task automatic wait_line(input string name, input int y);
        bit found = 1'b0;
        for (int i = 0; i < 3000 && !found; i++) begin
            @(negedge clk);
            if (int'(pixel_y) == y && pixel_x == 10'd0) found = 1'b1;
        end
        chk1(name, found, 1'b1);
    endtask

    // Returns 1 unit after the rising edge where ack reaches lvl.
    task automatic wait_ack(input string name, input logic lvl);
        bit found = 1'b0;
        for (int i = 0; i < 3000 && !found; i++) begin
            @(posedge clk);
            #1;
            if (bus.upd_ack === lvl) found = 1'b1;
        end
        chk1(name, found, 1'b1);
    endtask

    initial begin
        int ftc;
        bit done;
        logic pb, pc;
        int bt[$];
        int ct[$];

        rst = 1'b1;
        bus.upd_req  = 1'b0;
        bus.upd_data = '0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk1("rst_ack", bus.upd_ack, 1'b0);
        chk1("rst_pending", upd_pending, 1'b0);
        chkd("rst_disp", disp_data, '0);
        chk1("rst_frame_tick", frame_tick, 1'b0);
        chk1("rst_blink", blink, 1'b0);
        chk1("rst_cursor", blink_cursor, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Request in the visible area waits for blanking
        wait_line("B_line100", 100);
        bus.upd_data = 79'h1234;
        bus.upd_req  = 1'b1;
        wait_line("B_line479", 479);
        chkd("B_disp_hold", disp_data, '0);
        chk1("B_pending", upd_pending, 1'b1);
        chk1("B_no_ack", bus.upd_ack, 1'b0);
        wait_ack("B_ack_rise", 1'b1);
        chki("B_ack_y", int'(pixel_y), 480);
        chki("B_ack_x", int'(pixel_x), 1);
        chkd("B_disp", disp_data, 79'h1234);
        @(negedge clk);
        bus.upd_req = 1'b0;
        @(posedge clk);
        #1;
        chk1("B_ack_fall", bus.upd_ack, 1'b0);

        // Request inside blanking: ack exactly two clocks after first sample
        wait_line("C_line500", 500);
        bus.upd_data = 79'h5_5555_AAAA;
        bus.upd_req  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk1("C_ack_early", bus.upd_ack, 1'b0);
        @(posedge clk);
        #1;
        chk1("C_ack", bus.upd_ack, 1'b1);
        chkd("C_disp", disp_data, 79'h5_5555_AAAA);
        @(negedge clk);
        bus.upd_req = 1'b0;
        @(posedge clk);
        #1;
        chk1("C_ack_fall", bus.upd_ack, 1'b0);

        // Request raised on the last visible row commits in the same blanking;
        // a follow-up request is taken only after ack has fallen
        wait_line("D_line479", 479);
        bus.upd_data = 79'h7777;
        bus.upd_req  = 1'b1;
        wait_ack("D_ack_rise", 1'b1);
        chki("D_ack_y", int'(pixel_y), 480);
        chkd("D_disp", disp_data, 79'h7777);
        @(negedge clk);
        bus.upd_req = 1'b0;
        @(posedge clk);
        #1;
        chk1("D_ack_fall", bus.upd_ack, 1'b0);
        @(negedge clk);
        bus.upd_data = 79'h42_0000_0042;
        bus.upd_req  = 1'b1;
        @(posedge clk);
        #1;
        chk1("D_second_no_ack", bus.upd_ack, 1'b0);
        wait_ack("D_second_ack", 1'b1);
        chkd("D_second_disp", disp_data, 79'h42_0000_0042);
        @(negedge clk);
        bus.upd_req = 1'b0;

        // Withdrawn request while waiting: no commit, no ack
        wait_line("F_line200", 200);
        bus.upd_data = 79'hDEAD;
        bus.upd_req  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk1("F_pending", upd_pending, 1'b1);
        @(negedge clk);
        bus.upd_req = 1'b0;
        @(posedge clk);
        #1;
        chk1("F_pending_clr", upd_pending, 1'b0);
        wait_line("F_line490", 490);
        chkd("F_disp_kept", disp_data, 79'h42_0000_0042);
        chk1("F_no_ack", bus.upd_ack, 1'b0);

        // Reset in the middle of a handshake, requester keeps req high
        wait_line("E_line485", 485);
        bus.upd_data = 79'hBEEF;
        bus.upd_req  = 1'b1;
        wait_ack("E_ack_rise", 1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk1("E_async_ack", bus.upd_ack, 1'b0);
        chkd("E_async_disp", disp_data, '0);
        chk1("E_async_blink", blink, 1'b0);
        chk1("E_async_pending", upd_pending, 1'b0);
        wait_line("E_line10", 10);
        rst = 1'b0;
        wait_ack("E_reack", 1'b1);
        chki("E_reack_y", int'(pixel_y), 480);
        chkd("E_reack_disp", disp_data, 79'hBEEF);
        @(negedge clk);
        bus.upd_req = 1'b0;

        // Sixty frames of blink behaviour from a clean reset
        wait_line("G_line0", 0);
        rst  = 1'b1;
        fast = 1'b1;
        @(negedge clk);
        rst  = 1'b0;
        ftc  = 0;
        done = 1'b0;
        pb   = blink;
        pc   = blink_cursor;
        for (int i = 0; i < 40000 && !done; i++) begin
            @(posedge clk);
            #1;
            if (frame_tick) ftc++;
            if (blink !== pb) begin bt.push_back(ftc); pb = blink; end
            if (blink_cursor !== pc) begin ct.push_back(ftc); pc = blink_cursor; end
            if (ftc == 60 && !frame_tick) done = 1'b1;
        end
        chki("G_frame_ticks", ftc, 60);
        chki("G_blink_toggles", bt.size(), 3);
        for (int k = 0; k < 3; k++)
            chki($sformatf("G_blink_toggle%0d_frame", k), (k < bt.size()) ? bt[k] : -1, 20 * (k + 1));
        chki("G_cursor_toggles", ct.size(), 2);
        for (int k = 0; k < 2; k++)
            chki($sformatf("G_cursor_toggle%0d_frame", k), (k < ct.size()) ? ct[k] : -1, 30 * (k + 1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_update_scheduler.md
# vga_update_scheduler

Frame-synchronous update scheduler for the VGA display path. Sits between the RTC/configuration logic and the display controller, and accepts display-data updates over a 4-phase req/ack handshake. It commits each update to a shadow register only during vertical blanking, so the character generator never sees a mid-frame change (no tearing). It also produces the frame-locked alarm-blink and cursor-blink enables, replacing free-running clock-count dividers.

## Interface
Parameters:
- DATA_W, 79, width of the display bundle: 18 BCD digits (72) + AM_PM + formato_hora + config_mode(2) + cursor_location(2) + estado_alarma.
- V_VISIBLE, 480, first pixel_y value of vertical blanking.
- BLINK_FRAMES, 20, frames per alarm-blink half-period (1.5 Hz toggle at 60 Hz).
- CURSOR_FRAMES, 30, frames per cursor-blink half-period.

Ports:
- clock  in  1  system clock (100 MHz).
- reset  in  1  asynchronous, active-high; one clock, reset is asynchronous and active-high.
- pixel_tick  in  1  pixel enable from timing_generator_VGA.
- pixel_x  in  10  current pixel column.
- pixel_y  in  10  current pixel row.
- upd_req  in  1  update request; held high until upd_ack is seen high.
- upd_data  in  DATA_W  new bundle; must be stable while upd_req is high.
- upd_ack  out  1  handshake acknowledge.
- disp_data  out  DATA_W  shadow bundle driven to the character generator.
- upd_pending  out  1  request accepted, waiting for vblank.
- frame_tick  out  1  one-clock pulse at vblank entry.
- blink  out  1  alarm blink enable.
- blink_cursor  out  1  cursor blink enable.

## Operation
- in_vblank = (pixel_y >= V_VISIBLE), combinational.
- frame_tick = registered pulse, asserted for one clock after the clock where pixel_tick && pixel_x==0 && pixel_y==V_VISIBLE.
- FSM states:
  - IDLE: if upd_req, go to WAIT_VB.
  - WAIT_VB: upd_pending=1. If in_vblank, go to LATCH; otherwise stay.
  - LATCH: disp_data <= upd_data; upd_ack <= 1; go to REL.
  - REL: upd_ack held 1. When upd_req==0, upd_ack <= 0 and go to IDLE.
- upd_req dropping in WAIT_VB (protocol violation): return to IDLE, no latch, no ack.
- A new request is never accepted while upd_ack is high.
- Blink counters:
  - blink_cnt (width clog2(BLINK_FRAMES)) increments on frame_tick.
  - At BLINK_FRAMES-1 with frame_tick: blink_cnt clears and blink toggles.
  - The cursor counter works identically with CURSOR_FRAMES.
- Blink counters are independent of the FSM.

## Timing
- Reset values:
  - state=IDLE.
  - upd_ack=0, upd_pending=0, frame_tick=0.
  - blink=0, blink_cursor=0, both counters 0.
  - disp_data=0.
- Request during vblank: req sampled at edge 0 → WAIT_VB; edge 1 → LATCH; edge 2 → disp_data updated and upd_ack=1. Ack is visible 2 clocks after req is first sampled.
- Request during the visible area: latch occurs on the 2nd edge after in_vblank first goes true.
- vblank ending while in WAIT_VB: keep waiting for the next frame; maximum latency is one frame plus 2 clocks.
- upd_ack falls 1 clock after upd_req is sampled low.
- disp_data changes only on the LATCH edge, and only while in_vblank was true one clock earlier.
- pixel_y wrap (524→0) produces no frame_tick. Exactly one frame_tick occurs per frame.
- Reset asserted mid-operation (any state): all outputs return to reset values immediately. A requester holding upd_req through reset is re-serviced from IDLE.

## Test plan
- Reset mid-handshake: assert reset with state=REL and upd_ack=1 → upd_ack=0, disp_data=0, blink=0 asynchronously; after release with upd_req still high, a fresh ack follows in the next vblank.
- Request at pixel_y=100 with upd_data=79'h1234 → disp_data unchanged until pixel_y=480; disp_data=79'h1234 and upd_ack=1 two clocks after vblank entry; ack falls 1 clock after req drops.
- Request at pixel_y=500 → upd_ack=1 exactly 2 clocks after req; no wait for the next frame.
- Request at pixel_y=479 that spans vblank (req held throughout) → latch in the same vblank; a second request raised while ack is high is not acknowledged until the ack has fallen.
- Run 60 frames → 60 frame_tick pulses; blink toggles at frames 20, 40 and 60; blink_cursor toggles at frames 30 and 60.
- Drop upd_req while in WAIT_VB → return to IDLE; disp_data unchanged and no upd_ack pulse.
